// File: rtl/tune_pkg.sv
// Shared types and constants for the NCO tuning-word control stage.
package tune_pkg;

  // Write-sequence states: idle, fractional byte write, integer byte write.
  typedef enum logic [1:0] {
    StIdle,
    StWrF,
    StWrR
  } tune_state_e;

  // Tuning word is fixed at two bytes.
  localparam int unsigned TW_W     = 16;
  localparam int unsigned BYTE_W   = 8;
  // Byte lanes within the tuning word.
  localparam int unsigned DIVF_LSB = 0;
  localparam int unsigned DIVR_LSB = 8;
  // Prescale counter width; covers PRESCALE up to 255.
  localparam int unsigned CNT_W    = 8;

endpackage

// File: rtl/en_prescaler.sv
// Programmable step-strobe generator for the phase accumulator.
// The count holds at its terminal value while 'hold' is high so a step that
// falls inside a write pair is delivered late rather than lost.
module en_prescaler
  import tune_pkg::*;
#(
  parameter int unsigned PRESCALE = 4  // legal range 1..255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hold,
  output logic en
);

  localparam logic [CNT_W-1:0] TermCount = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             en_q, en_d;

  // Next count and strobe: clear when stopped, wrap at terminal, hold when blocked.
  always_comb begin
    count_d = count_q;
    en_d    = 1'b0;
    if (!run) begin
      count_d = '0;
    end else if (count_q == TermCount) begin
      if (!hold) begin
        en_d    = 1'b1;
        count_d = '0;
      end
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // Count and strobe registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      en_q    <= en_d;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/tune_ctrl.sv
// Upstream control for the 8-bit NCO: accepts a 16-bit tuning word and writes
// it to the accumulator as fractional byte then integer byte, while generating
// the accumulator step strobe and masking it during the write pair.
module tune_ctrl
  import tune_pkg::*;
#(
  parameter int unsigned PRESCALE = 4  // en period in clk cycles, 1..255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              tw_valid,
  output logic              tw_ready,
  input  logic [TW_W-1:0]   tw_word,
  output logic [BYTE_W-1:0] data,
  output logic              wr_divf,
  output logic              wr_divr,
  output logic              en,
  output logic              busy,
  output logic              loaded
);

  tune_state_e       state_q, state_d;
  logic [BYTE_W-1:0] divr_q, divr_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              wr_divf_q, wr_divf_d;
  logic              wr_divr_q, wr_divr_d;
  logic              loaded_q, loaded_d;
  logic              busy_q, busy_d;
  logic              accept;

  assign tw_ready = (state_q == StIdle) & rst;
  assign accept   = tw_valid & tw_ready;

  // Next-state and registered-output values. Outputs are computed one cycle
  // early so each strobe is high exactly during the matching state.
  always_comb begin
    state_d   = state_q;
    divr_d    = divr_q;
    data_d    = data_q;
    wr_divf_d = 1'b0;
    wr_divr_d = 1'b0;
    loaded_d  = loaded_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StWrF;
          divr_d    = tw_word[DIVR_LSB +: BYTE_W];
          data_d    = tw_word[DIVF_LSB +: BYTE_W];
          wr_divf_d = 1'b1;
        end
      end
      StWrF: begin
        state_d   = StWrR;
        data_d    = divr_q;
        wr_divr_d = 1'b1;
      end
      StWrR: begin
        state_d  = StIdle;
        loaded_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture register and bus/status output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      divr_q    <= '0;
      data_q    <= '0;
      wr_divf_q <= 1'b0;
      wr_divr_q <= 1'b0;
      loaded_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      divr_q    <= divr_d;
      data_q    <= data_d;
      wr_divf_q <= wr_divf_d;
      wr_divr_q <= wr_divr_d;
      loaded_q  <= loaded_d;
      busy_q    <= busy_d;
    end
  end

  assign data    = data_q;
  assign wr_divf = wr_divf_q;
  assign wr_divr = wr_divr_q;
  assign busy    = busy_q;
  assign loaded  = loaded_q;

  // Hold uses next-state busy so en is never high in the same cycle as a
  // write strobe and fires in the first idle cycle after the pair.
  en_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_en_prescaler (
    .clk (clk),
    .rst (rst),
    .run (run),
    .hold(busy_d),
    .en  (en)
  );

endmodule

// File: tb/tb_tune_ctrl.sv
// Self-checking bench for tune_ctrl: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model. Two instances
// (PRESCALE=4 and PRESCALE=1) share all inputs.
module tb_tune_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        tw_valid = 1'b0;
  logic [15:0] tw_word = 16'h0000;

  logic        tw_ready, wr_divf, wr_divr, en, busy, loaded;
  logic [7:0]  data;
  logic        tw_ready_p1, wr_divf_p1, wr_divr_p1, en_p1, busy_p1, loaded_p1;
  logic [7:0]  data_p1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  tune_ctrl #(.PRESCALE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .tw_valid(tw_valid),
    .tw_ready(tw_ready),
    .tw_word (tw_word),
    .data    (data),
    .wr_divf (wr_divf),
    .wr_divr (wr_divr),
    .en      (en),
    .busy    (busy),
    .loaded  (loaded)
  );

  tune_ctrl #(.PRESCALE(1)) dut_p1 (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .tw_valid(tw_valid),
    .tw_ready(tw_ready_p1),
    .tw_word (tw_word),
    .data    (data_p1),
    .wr_divf (wr_divf_p1),
    .wr_divr (wr_divr_p1),
    .en      (en_p1),
    .busy    (busy_p1),
    .loaded  (loaded_p1)
  );

  // Reference model: the bus is a queue of pending byte writes; the step
  // strobe is owed after P run-high cycles and delivered on an idle cycle.
  typedef enum {EvNone, EvF, EvR} ev_e;
  typedef struct {ev_e k; logic [7:0] d;} ev_t;

  ev_t         m_q[$];
  ev_e         m_cur = EvNone;
  logic [7:0]  m_data = 8'h00;
  logic        m_loaded = 1'b0;
  logic        m_en4 = 1'b0, m_en1 = 1'b0;
  int unsigned m_el4 = 0, m_el1 = 0;

  logic [9:0]  bus_log[$];
  int          acc_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned en_step(input int unsigned el, input int unsigned p,
                                          input bit idle_next, output logic en_o);
    int unsigned e;
    en_o = 1'b0;
    if (!run) return 0;
    e = (el >= p) ? p : el + 1;
    if (e == p && idle_next) begin
      en_o = 1'b1;
      e = 0;
    end
    return e;
  endfunction

  task automatic model_edge();
    ev_t e;
    if (!rst) begin
      m_q.delete();
      m_cur = EvNone; m_data = 8'h00; m_loaded = 1'b0;
      m_el4 = 0; m_el1 = 0; m_en4 = 1'b0; m_en1 = 1'b0;
      return;
    end
    if (m_cur == EvR) m_loaded = 1'b1;
    if (m_cur == EvNone && tw_valid) begin
      m_q.push_back('{k: EvF, d: tw_word[7:0]});
      m_q.push_back('{k: EvR, d: tw_word[15:8]});
    end
    if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_cur = e.k;
      m_data = e.d;
    end else begin
      m_cur = EvNone;
    end
    m_el4 = en_step(m_el4, 4, m_cur == EvNone, m_en4);
    m_el1 = en_step(m_el1, 1, m_cur == EvNone, m_en1);
  endtask

  // One clock: check the combinational ready, advance the model, then check
  // all registered outputs just after the edge.
  task automatic cycle();
    #1;
    check_eq("tw_ready", tw_ready, (m_cur == EvNone) && rst);
    if (tw_valid && tw_ready) acc_q.push_back(cyc + 1);
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("data", data, m_data);
    check_eq("wr_divf", wr_divf, m_cur == EvF);
    check_eq("wr_divr", wr_divr, m_cur == EvR);
    check_eq("busy", busy, m_cur != EvNone);
    check_eq("loaded", loaded, m_loaded);
    check_eq("en", en, m_en4);
    check_eq("en_p1", en_p1, m_en1);
    check_eq("no_overlap", wr_divf & wr_divr, 0);
    if (wr_divf || wr_divr) bus_log.push_back({wr_divf, wr_divr, data});
  endtask

  initial begin
    int cnt;
    int first;
    logic [9:0] exp_bus[4];

    // Reset held for three cycles.
    rst = 1'b0; run = 1'b0; tw_valid = 1'b0;
    repeat (3) cycle();
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_loaded", loaded, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", tw_ready, 0);

    // Single word.
    rst = 1'b1;
    tw_word = 16'h1A40; tw_valid = 1'b1;
    cycle();
    tw_valid = 1'b0;
    check_eq("w1_divf", wr_divf, 1);
    check_eq("w1_data_f", data, 8'h40);
    cycle();
    check_eq("w1_divr", wr_divr, 1);
    check_eq("w1_data_r", data, 8'h1A);
    cycle();
    check_eq("w1_ready", tw_ready, 1);
    check_eq("w1_loaded", loaded, 1);

    // Prescaler cadence, no writes.
    run = 1'b1; cnt = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (en) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    check_eq("cad_pulses", cnt, 5);
    check_eq("cad_first", first, 4);
    run = 1'b0;
    cycle();
    check_eq("run_off_en", en, 0);

    // Collision: handshake lands on the terminal-count edge (4th edge).
    // Step delayed to the 6th edge, then every 4: 6,10,..,38 -> 9 pulses.
    run = 1'b1; cnt = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4) begin
        tw_valid = 1'b1;
        tw_word = 16'($urandom);
      end
      cycle();
      tw_valid = 1'b0;
      if (en) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    check_eq("col_first", first, 6);
    check_eq("col_pulses", cnt, 9);
    run = 1'b0;
    cycle();

    // Back-to-back words with valid held high.
    acc_q.delete(); bus_log.delete();
    tw_word = 16'h0102; tw_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (acc_q.size() == 1) tw_word = 16'h0304;
      if (acc_q.size() >= 2) tw_valid = 1'b0;
    end
    tw_valid = 1'b0;
    check_eq("b2b_accepts", acc_q.size(), 2);
    if (acc_q.size() >= 2) check_eq("b2b_gap", acc_q[1] - acc_q[0], 3);
    exp_bus[0] = {2'b10, 8'h02};
    exp_bus[1] = {2'b01, 8'h01};
    exp_bus[2] = {2'b10, 8'h04};
    exp_bus[3] = {2'b01, 8'h03};
    check_eq("b2b_bus_len", bus_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < bus_log.size()) check_eq("b2b_bus", bus_log[i], exp_bus[i]);
    end

    // Reset during WR_F.
    tw_word = 16'hBEEF; tw_valid = 1'b1;
    cycle();
    tw_valid = 1'b0;
    check_eq("mid_in_wrf", wr_divf, 1);
    bus_log.delete();
    rst = 1'b0;
    cycle();
    check_eq("mid_data", data, 8'h00);
    check_eq("mid_loaded", loaded, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_ready", tw_ready, 0);
    cycle();
    check_eq("mid_ready2", tw_ready, 0);
    rst = 1'b1;
    repeat (3) cycle();
    check_eq("mid_no_divr", bus_log.size(), 0);

    // PRESCALE=1: one write pair masks exactly two of ten steps.
    run = 1'b1;
    repeat (2) cycle();
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) begin
        tw_valid = 1'b1;
        tw_word = 16'($urandom);
      end
      cycle();
      tw_valid = 1'b0;
      if (en_p1) cnt++;
    end
    check_eq("p1_pulses", cnt, 8);
    run = 1'b0;
    cycle();
    check_eq("p1_run_off", en_p1, 0);

    // Random traffic, occasional reset and run toggles.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) >= 3);
      if ($urandom_range(0, 9) == 0) run = ~run;
      tw_valid = 1'($urandom_range(0, 1));
      tw_word = 16'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tune_ctrl.md
Name: tune_ctrl

Overview:
- Upstream control stage for the 8-bit phase accumulator (NCO).
- Accepts a 16-bit tuning word over a valid/ready handshake and serialises it onto the accumulator's shared byte bus as two one-cycle writes: fractional byte first (wr_divf), then integer byte (wr_divr).
- Generates the accumulator's en step strobe from a programmable prescaler.
- Blocks en while a write pair is in flight, so the accumulator never steps on a half-updated increment.

Parameters:
- PRESCALE, 4: en strobe period in clk cycles while run=1; legal range 1..255.
- TW_W, 16: tuning word width, fixed as 2 x 8 bits.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- run  in  1  level; 1 = generate en strobes
- tw_valid  in  1  tuning word offered
- tw_ready  out  1  block can accept a word
- tw_word  in  16  [15:8] integer increment (divr), [7:0] fractional increment (divf)
- data  out  8  byte bus to accumulator
- wr_divf  out  1  one-cycle write strobe, fractional increment
- wr_divr  out  1  one-cycle write strobe, integer increment
- en  out  1  accumulator step strobe
- busy  out  1  write sequence in progress
- loaded  out  1  sticky; at least one full word has been written since reset

Behaviour:
- Reset (rst=0 at posedge) sets:
  - state=IDLE; data=8'h00; wr_divf=0; wr_divr=0; en=0; busy=0; loaded=0; prescale count=0.
  - tw_ready is forced to 0 while rst=0.
- Reset mid-sequence aborts the sequence. Any pending strobe is dropped, and no partial second write occurs after reset.
- FSM states: IDLE, WR_F, WR_R. All outputs except tw_ready are registered.
- tw_ready = (state==IDLE) & rst. This is combinational from state.
- IDLE: on tw_valid & tw_ready, capture tw_word and go to WR_F.
- WR_F (1 cycle):
  - data=word[7:0], wr_divf=1.
  - Go to WR_R.
- WR_R (1 cycle):
  - data=word[15:8], wr_divr=1, wr_divf=0.
  - Go to IDLE; set loaded=1.
- Timing from a handshake at edge N:
  - wr_divf is high during cycle N+1.
  - wr_divr is high during cycle N+2.
  - tw_ready returns to 1 in cycle N+3.
  - Back-to-back words therefore get 3-cycle throughput.
- data holds its last driven value when no strobe is active. wr_divf and wr_divr are never high together.
- busy = (state != IDLE).
- Prescaler (run=1):
  - The count advances 0..PRESCALE-1 and wraps.
  - en=1 for one cycle when count==PRESCALE-1 and state==IDLE.
  - PRESCALE=1 gives en high on every IDLE cycle.
- Strobe collision: if the terminal count is reached while not IDLE, the count holds at PRESCALE-1. en fires on the first IDLE cycle, so no step is lost and none is duplicated. The count then resumes at 0.
- run=0: the count clears to 0 and en=0 at the next edge. Writes are still accepted.
- run 0->1: the first en comes PRESCALE cycles after run is sampled high, assuming IDLE throughout.
- en is generated regardless of loaded.

Decomposition:
- Package tune_pkg holds:
  - the state enum (IDLE, WR_F, WR_R);
  - TW_W=16 and the byte-lane constants (DIVF_LSB=0, DIVR_LSB=8).
- Sub-module en_prescaler contains:
  - the count register;
  - the terminal-count hold input (driven by busy);
  - the registered en output.
- tune_ctrl contains the FSM, the capture register and the bus drive.

Test Plan:
- Reset, then a single word:
  - Stimulus: rst low 3 cycles, then high; run=0; tw_word=16'h1A40 with tw_valid one cycle.
  - Required: wr_divf with data=8'h40 at N+1; wr_divr with data=8'h1A at N+2; tw_ready=1 at N+3; loaded=1 from N+3.
- Prescaler cadence:
  - Stimulus: PRESCALE=4, run=1 for 20 cycles, no writes.
  - Required: en high exactly on every 4th cycle, 5 pulses, first pulse 4 cycles after run is sampled high.
- Collision:
  - Stimulus: PRESCALE=4, run=1; handshake timed so that the terminal count lands in WR_F.
  - Required: en stays low during WR_F and WR_R, fires in the first IDLE cycle, then the next en is 4 cycles later. No lost or duplicate steps over 40 cycles (count the en pulses against the expected total).
- Back-to-back words:
  - Stimulus: tw_valid held high with 16'h0102 then 16'h0304.
  - Required: the second handshake occurs 3 cycles after the first. Bus sequence is 02,01,04,03 with alternating strobes, wr_divf and wr_divr never overlapping.
- Mid-sequence reset:
  - Stimulus: rst low during WR_F.
  - Required: wr_divr never asserts; data=8'h00; loaded=0; busy=0; tw_ready=0 until rst is high again.
- PRESCALE=1 with run toggling:
  - Required: en high on every IDLE cycle while run=1; en low one edge after run falls; a write pair masks exactly 2 en cycles.
